// File: rtl/ddr_20g_adc_packer_pkg.sv
// Shared framing constants for the 20G ADC stream.
// A frame is 12 input slots (4 heads + 8 ADC words) carried in 9 x 256-bit
// beats. The slot-type rule marks slots 0, 3, 6 and 9 as head slots. The
// parser on the receive side uses the same constants.
package ddr_20g_adc_packer_pkg;

  localparam int LANE_WD       = 64;
  localparam int ADC_FRM_SLOTS = 12;
  localparam int ADC_FRM_BEATS = 9;

  localparam logic [3:0] SLOT_LAST = 4'(ADC_FRM_SLOTS - 1);
  localparam logic [3:0] BEAT_LAST = 4'(ADC_FRM_BEATS - 1);

  typedef enum logic {
    SLOT_ADC  = 1'b0,
    SLOT_HEAD = 1'b1
  } slot_type_e;

  // Every third slot, starting at slot 0, carries a head.
  function automatic slot_type_e slot_type(input logic [3:0] slot);
    if (slot == 4'd0 || slot == 4'd3 || slot == 4'd6 || slot == 4'd9)
      return SLOT_HEAD;
    return SLOT_ADC;
  endfunction

endpackage

// File: rtl/ddr_20g_adc_packer.sv
// Transmit-side framer for the 20G ADC stream.
// Interleaves a 64-bit head stream and a 256-bit ADC stream in the lane
// order H A A H A A H A A H A A and packs the 36 lanes little-endian into
// 9 output beats of 256 bits. Output is a single register stage.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cfg_rst          synchronous soft reset, drops any partial frame
//   s_head_*         64-bit head AXI-Stream sink
//   s_adc_*          256-bit ADC AXI-Stream sink
//   m_axis_*         256-bit framed AXI-Stream source, tlast on beat 8
//   frame_done       1-cycle pulse after beat 8 is accepted
module ddr_20g_adc_packer
  import ddr_20g_adc_packer_pkg::*;
#(
  parameter int DATA_WD = 256,  // only 256 supported
  parameter int HEAD_WD = 64    // only 64 supported
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_rst,
  input  logic [HEAD_WD-1:0] s_head_tdata,
  input  logic               s_head_tvalid,
  output logic               s_head_tready,
  input  logic [DATA_WD-1:0] s_adc_tdata,
  input  logic               s_adc_tvalid,
  output logic               s_adc_tready,
  output logic [DATA_WD-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               frame_done
);

  // Up to three residual lanes can be left over after a beat is emitted.
  localparam int RES_WD = DATA_WD - LANE_WD;
  localparam int CMB_WD = DATA_WD + RES_WD;

  logic [3:0]         slot_q,   slot_d;
  logic [2:0]         fill_q,   fill_d;
  logic [RES_WD-1:0]  resid_q,  resid_d;
  logic [3:0]         beat_q,   beat_d;
  logic [DATA_WD-1:0] tdata_q,  tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               done_q,   done_d;
  // Holds the input readys low while in reset and for the cycle after a
  // soft reset, so no word is taken before the frame restarts at H0.
  logic               en_q,     en_d;

  logic               is_head;
  logic               can_acc;
  logic               head_rdy;
  logic               adc_rdy;
  logic               acc;
  logic [DATA_WD-1:0] in_w;
  logic [CMB_WD-1:0]  comb_w;
  logic [2:0]         n_lanes;

  always_comb begin
    is_head  = (slot_type(slot_q) == SLOT_HEAD);
    can_acc  = ~tvalid_q | m_axis_tready;
    head_rdy = en_q & ~cfg_rst &  is_head & can_acc;
    adc_rdy  = en_q & ~cfg_rst & ~is_head & can_acc;
    acc      = (head_rdy & s_head_tvalid) | (adc_rdy & s_adc_tvalid);

    in_w = is_head ? {{(DATA_WD-HEAD_WD){1'b0}}, s_head_tdata} : s_adc_tdata;

    // Lane shifter: place the new word above the residual lanes.
    case (fill_q)
      3'd0:    comb_w = {{RES_WD{1'b0}}, in_w};
      3'd1:    comb_w = {{(RES_WD-LANE_WD){1'b0}}, in_w, {LANE_WD{1'b0}}};
      3'd2:    comb_w = {{LANE_WD{1'b0}}, in_w, {(2*LANE_WD){1'b0}}};
      default: comb_w = {in_w, {RES_WD{1'b0}}};
    endcase
    comb_w = comb_w | {{DATA_WD{1'b0}}, resid_q};

    // fill <= 3, so the sum never exceeds 7.
    n_lanes = fill_q + (is_head ? 3'd1 : 3'd4);
  end

  assign s_head_tready = head_rdy;
  assign s_adc_tready  = adc_rdy;

  always_comb begin
    slot_d   = slot_q;
    fill_d   = fill_q;
    resid_d  = resid_q;
    beat_d   = beat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;
    en_d     = 1'b1;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
      beat_d   = (beat_q == BEAT_LAST) ? 4'd0 : beat_q + 4'd1;
      done_d   = (beat_q == BEAT_LAST);
    end

    if (acc) begin
      slot_d = (slot_q == SLOT_LAST) ? 4'd0 : slot_q + 4'd1;
      if (n_lanes[2]) begin
        // Four or more lanes available: emit one full beat.
        tdata_d  = comb_w[DATA_WD-1:0];
        tvalid_d = 1'b1;
        resid_d  = comb_w[CMB_WD-1:DATA_WD];
        fill_d   = {1'b0, n_lanes[1:0]};
      end else begin
        resid_d = comb_w[RES_WD-1:0];
        fill_d  = n_lanes;
      end
    end

    if (cfg_rst) begin
      slot_d   = 4'd0;
      fill_d   = 3'd0;
      resid_d  = '0;
      beat_d   = 4'd0;
      tdata_d  = '0;
      tvalid_d = 1'b0;
      done_d   = 1'b0;
      en_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= 4'd0;
      fill_q   <= 3'd0;
      resid_q  <= '0;
      beat_q   <= 4'd0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      fill_q   <= fill_d;
      resid_q  <= resid_d;
      beat_q   <= beat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      en_q     <= en_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q & (beat_q == BEAT_LAST);
  assign frame_done    = done_q;

endmodule

// File: tb/tb_ddr_20g_adc_packer.sv
module tb_ddr_20g_adc_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_rst;
  logic [63:0]  s_head_tdata;
  logic         s_head_tvalid;
  logic         s_head_tready;
  logic [255:0] s_adc_tdata;
  logic         s_adc_tvalid;
  logic         s_adc_tready;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         frame_done;

  always #5 clk = ~clk;

  ddr_20g_adc_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_rst       (cfg_rst),
    .s_head_tdata  (s_head_tdata),
    .s_head_tvalid (s_head_tvalid),
    .s_head_tready (s_head_tready),
    .s_adc_tdata   (s_adc_tdata),
    .s_adc_tvalid  (s_adc_tvalid),
    .s_adc_tready  (s_adc_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done)
  );

  int errs = 0;
  int nchk = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Expected beats (written by the stimulus) and captured beats (monitor).
  logic [255:0] exp_mem [0:511];
  logic [255:0] cap_mem [0:511];
  int wr_idx = 0;
  int rd_idx = 0;
  int obs_cnt = 0;

  // Current frame content.
  logic [63:0]  hd [0:3];
  logic [255:0] ad [0:7];

  function automatic logic [255:0] frame_beat(input int b);
    case (b)
      0:       return {ad[0][191:0], hd[0]};
      1:       return {ad[1][191:0], ad[0][255:192]};
      2:       return {ad[2][127:0], hd[1], ad[1][255:192]};
      3:       return {ad[3][127:0], ad[2][255:128]};
      4:       return {ad[4][63:0], hd[2], ad[3][255:128]};
      5:       return {ad[5][63:0], ad[4][255:64]};
      6:       return {hd[3], ad[5][255:64]};
      7:       return ad[6];
      default: return ad[7];
    endcase
  endfunction

  task automatic make_frame(input int f, input bit rnd);
    for (int n = 0; n < 4; n++)
      hd[n] = rnd ? {$urandom, $urandom}
                  : (64'hAAAA_0000_0000_0000 | (64'(f) << 16) | 64'(n));
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++)
        ad[k][64*j +: 64] = rnd ? {$urandom, $urandom}
                                : (64'hB000_0000_0000_0000 | (64'(k) << 52) | (64'(f) << 16) | 64'(j));
  endtask

  task automatic push_beats(input int lo, input int hi);
    for (int b = lo; b <= hi; b++) begin
      exp_mem[wr_idx & 511] = frame_beat(b);
      wr_idx++;
    end
  endtask

  // Present one word and hold it until the DUT takes it; called at a negedge.
  task automatic send_item(input bit is_h, input logic [255:0] d, input bit junk, inout int waits);
    logic rdy;
    rdy = 1'b0;
    if (is_h) begin
      s_head_tdata  = d[63:0];
      s_head_tvalid = 1'b1;
      s_adc_tdata   = {8{32'hDEAD_BEEF}};
      s_adc_tvalid  = junk;
    end else begin
      s_adc_tdata   = d;
      s_adc_tvalid  = 1'b1;
      s_head_tdata  = 64'hBADB_BADB_BADB_BADB;
      s_head_tvalid = junk;
    end
    for (int t = 0; t < 100; t++) begin
      #1;
      rdy = is_h ? s_head_tready : s_adc_tready;
      if (rdy) break;
      @(negedge clk);
      waits++;
    end
    check("hs_ready", rdy, 1'b1);
    if (junk) check("unselected_ready", is_h ? s_adc_tready : s_head_tready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    s_head_tvalid = 1'b0;
    s_adc_tvalid  = 1'b0;
  endtask

  task automatic send_slots(input int lo, input int hi, input bit junk, inout int waits);
    for (int s = lo; s <= hi; s++) begin
      if (s % 3 == 0) send_item(1'b1, {192'b0, hd[s/3]}, junk, waits);
      else            send_item(1'b0, ad[(s/3)*2 + (s%3) - 1], junk, waits);
    end
  endtask

  task automatic send_frame(input int f, input bit rnd, input bit junk, inout int waits);
    make_frame(f, rnd);
    push_beats(0, 8);
    send_slots(0, 11, junk, waits);
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 300 && rd_idx != wr_idx; t++) @(negedge clk);
    check(tag, rd_idx, wr_idx);
  endtask

  // Downstream ready pattern: 0 always ready, 1 toggling with a 5-cycle
  // stall before b4, 2 held low.
  int rdy_mode = 0;
  int stall_left = 0;
  int last_stall_at = -1;

  always @(negedge clk) begin
    if (rdy_mode == 0) m_axis_tready = 1'b1;
    else if (rdy_mode == 2) m_axis_tready = 1'b0;
    else if (stall_left > 0) begin
      m_axis_tready = 1'b0;
      stall_left--;
    end else if ((obs_cnt % 9) == 4 && obs_cnt != last_stall_at && m_axis_tvalid) begin
      last_stall_at = obs_cnt;
      stall_left    = 4;
      m_axis_tready = 1'b0;
    end else m_axis_tready = ~m_axis_tready;
  end

  // Output monitor, sampled just before the next rising edge.
  logic [255:0] prev_data = '0;
  logic prev_stall = 1'b0;
  logic prev_last_acc = 1'b0;

  always @(negedge clk) begin
    logic acc_last;
    #2;
    acc_last = 1'b0;
    if (!rst_n || cfg_rst) begin
      obs_cnt       = 0;
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
    end else begin
      check("frame_done", frame_done, prev_last_acc);
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && !m_axis_tready)
        check("ready_in_stall", {s_head_tready, s_adc_tready}, 2'b00);
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat", m_axis_tdata, exp_mem[rd_idx & 511]);
        check("tlast", m_axis_tlast, (obs_cnt % 9) == 8);
        cap_mem[rd_idx & 511] = m_axis_tdata;
        acc_last = ((obs_cnt % 9) == 8);
        rd_idx++;
        obs_cnt++;
      end
      prev_stall    = m_axis_tvalid & ~m_axis_tready;
      prev_data     = m_axis_tdata;
      prev_last_acc = acc_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int base;
    rst_n         = 1'b0;
    cfg_rst       = 1'b0;
    s_head_tdata  = '0;
    s_head_tvalid = 1'b0;
    s_adc_tdata   = '0;
    s_adc_tvalid  = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state, with both sources offering data.
    repeat (3) @(negedge clk);
    s_head_tvalid = 1'b1;
    s_adc_tvalid  = 1'b1;
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 256'h0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_readys", {s_head_tready, s_adc_tready}, 2'b00);
    @(negedge clk);
    s_head_tvalid = 1'b0;
    s_adc_tvalid  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 1: one frame with the reference lane pattern.
    waits = 0;
    base  = rd_idx;
    send_frame(0, 1'b0, 1'b0, waits);
    wait_drain("t1_drain");
    check("t1_b0", cap_mem[base],
          256'hB000_0000_0000_0002_B000_0000_0000_0001_B000_0000_0000_0000_AAAA_0000_0000_0000);
    check("t1_b2", cap_mem[base+2],
          256'hB020_0000_0000_0001_B020_0000_0000_0000_AAAA_0000_0000_0001_B010_0000_0000_0003);
    check("t1_b6", cap_mem[base+6],
          256'hAAAA_0000_0000_0003_B050_0000_0000_0003_B050_0000_0000_0002_B050_0000_0000_0001);
    check("t1_b8", cap_mem[base+8],
          256'hB070_0000_0000_0003_B070_0000_0000_0002_B070_0000_0000_0001_B070_0000_0000_0000);

    // 2: three back-to-back frames at full rate.
    waits = 0;
    base  = rd_idx;
    for (int f = 1; f <= 3; f++) send_frame(f, 1'b0, 1'b0, waits);
    wait_drain("t2_drain");
    check("t2_input_stalls", waits, 0);
    check("t2_beats", rd_idx - base, 27);

    // 3: toggling downstream ready with a long stall at b4.
    waits   = 0;
    rdy_mode = 1;
    for (int f = 4; f <= 5; f++) send_frame(f, 1'b0, 1'b0, waits);
    wait_drain("t3_drain");
    check("t3_saw_backpressure", waits > 0, 1'b1);
    rdy_mode = 0;
    @(negedge clk);

    // 4: the unselected source keeps tvalid high.
    waits = 0;
    send_frame(6, 1'b0, 1'b1, waits);
    wait_drain("t4_drain");

    // 5: soft reset mid-frame with a beat pending.
    waits = 0;
    make_frame(7, 1'b0);
    push_beats(0, 3);
    send_slots(0, 5, 1'b0, waits);
    wait_drain("t5_partial_drain");
    rdy_mode = 2;
    @(negedge clk);
    send_slots(6, 7, 1'b0, waits);
    @(negedge clk);
    #1;
    check("t5_pending_valid", m_axis_tvalid, 1'b1);
    @(negedge clk);
    cfg_rst       = 1'b1;
    s_head_tvalid = 1'b1;
    s_head_tdata  = 64'hBADB_BADB_BADB_BADB;
    #1;
    check("t5_ready_in_cfg_rst", {s_head_tready, s_adc_tready}, 2'b00);
    @(negedge clk);
    cfg_rst       = 1'b0;
    s_head_tvalid = 1'b0;
    #1;
    check("t5_valid_dropped", m_axis_tvalid, 1'b0);
    check("t5_tdata_cleared", m_axis_tdata, 256'h0);
    rdy_mode = 0;
    @(negedge clk);
    base = rd_idx;
    send_frame(8, 1'b0, 1'b0, waits);
    wait_drain("t5_drain");
    check("t5_fresh_b0", cap_mem[base],
          256'hB000_0000_0008_0002_B000_0000_0008_0001_B000_0000_0008_0000_AAAA_0000_0008_0000);

    // 6: random frames under toggling backpressure.
    waits    = 0;
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) send_frame(f, 1'b1, f[0], waits);
    wait_drain("t6_drain");
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
